// File: rtl/xm23_mem_interface.sv
// ---------------------------------------------------------------------------
// xm23_mem_interface
//
// Purpose:
//   Bridges the XM23 core's MAR/MDR request path to a dual-byte-port RAM.
//   The RAM has a lower-byte port and an upper-byte port, each with its own
//   byte address, write enable and write/read data. One word or byte
//   transaction is carried per handshake and takes exactly three cycles:
//   IDLE (accept) -> ACCESS (address/we on the RAM) -> RESP (result pulse).
//   A debug read port borrows the RAM only when the core is not requesting.
//   Byte order is little-endian: the low byte lives at the even address.
//
// Handshake:
//   A core request is taken at a rising edge where req_valid and req_ready
//   are both 1. req_ready is a register: it drops on the accept edge and
//   rises again on the edge that leaves RESP. req_* are sampled only at the
//   accept edge. Responses are not backpressured: rsp_* are valid for the
//   single cycle where rsp_valid is 1 and the consumer must take them then.
//   dbg_req is a level; a debug read is taken from IDLE only when no core
//   request is taken at that edge, and completes with a one-cycle dbg_valid.
//
// Ports:
//   Clock, Reset_n        clock (rising edge), async active-low reset
//   req_valid/req_ready   core request handshake
//   req_write, req_byte   1 = write / 1 = byte access
//   req_addr, req_wdata   byte address, write data (byte uses [7:0])
//   rsp_valid             one-cycle completion pulse for core requests
//   rsp_rdata, rsp_fault  read data and alignment fault, valid with rsp_valid
//   dbg_req, dbg_addr     debug word read request (level) and address
//   dbg_valid, dbg_rdata  one-cycle debug completion pulse and read word
//   mem_lb_*, mem_ub_*    lower/upper byte RAM port: addr, wdata, we, rdata
//                         (rdata returns one cycle after the address)
//   fsm_state             current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Configuration:
//   XM23_MEMIF_ALIGN_FAULT_EN  when defined, a core word access to an odd
//     address runs the normal three-cycle sequence but writes nothing,
//     returns rsp_rdata = 0 and raises rsp_fault with rsp_valid. When not
//     defined, bit 0 of a word address is silently cleared and rsp_fault
//     is tied to 0. Debug reads are always aligned and never fault.
// ---------------------------------------------------------------------------
module xm23_mem_interface #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    // core request / response
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    // debug read port
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_rdata,
    // dual-byte-port RAM
    output logic [ADDR_W-1:0] mem_lb_addr,
    output logic [ADDR_W-1:0] mem_ub_addr,
    output logic [7:0]        mem_lb_wdata,
    output logic [7:0]        mem_ub_wdata,
    output logic              mem_lb_we,
    output logic              mem_ub_we,
    input  logic [7:0]        mem_lb_rdata,
    input  logic [7:0]        mem_ub_rdata,
    // FSM observation
    output logic [1:0]        fsm_state
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;

    // Transaction captured at the accept edge.
    logic              write_q;
    logic              byte_q;
    logic              dbg_src_q;   // 1 = debug read, 0 = core request
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Held copies of the last response data, shown outside the RESP cycle.
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    // Decoded state and datapath helpers.
    logic              in_access;
    logic              in_resp;
    logic              misalign;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] core_data;

    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);

    // -----------------------------------------------------------------------
    // Alignment fault detection. Debug reads and byte accesses never fault.
    // -----------------------------------------------------------------------
`ifdef XM23_MEMIF_ALIGN_FAULT_EN
    assign misalign = ~dbg_src_q & ~byte_q & addr_q[0];
`else
    assign misalign = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Sequential control: FSM, req_ready, transaction latches, held data.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            dbg_src_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is only low in IDLE on the first edge after
                    // reset release; that edge just opens the interface and
                    // accepts nothing, so core and debug see the same start.
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        write_q   <= req_write;
                        byte_q    <= req_byte;
                        dbg_src_q <= 1'b0;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end else if (dbg_req) begin
                        // Debug is always an aligned word read.
                        write_q   <= 1'b0;
                        byte_q    <= 1'b0;
                        dbg_src_q <= 1'b1;
                        addr_q    <= dbg_addr;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    if (dbg_src_q) begin
                        dbg_rdata_q <= rd_word;
                    end else begin
                        rsp_rdata_q <= core_data;
                    end
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RAM address and write-data generation (ACCESS cycle only).
    // A word access uses the even address on the lower port and the odd
    // address on the upper port; a byte access puts its own address on the
    // lower port. The upper address is always addr|1, so no carry is ever
    // generated (0xFFFE word -> 0xFFFF on the upper port).
    // -----------------------------------------------------------------------
    assign eff_addr = {addr_q[ADDR_W-1:1], addr_q[0] & byte_q};

    assign mem_lb_addr  = in_access ? eff_addr : '0;
    assign mem_ub_addr  = in_access ? {addr_q[ADDR_W-1:1], 1'b1} : '0;
    assign mem_lb_wdata = in_access ? wdata_q[7:0]  : 8'h00;
    assign mem_ub_wdata = in_access ? wdata_q[15:8] : 8'h00;

    // Enables are decoded from state so an asynchronous reset drops them
    // at once, without waiting for a clock edge.
    assign mem_lb_we = in_access & write_q & ~misalign;
    assign mem_ub_we = in_access & write_q & ~misalign & ~byte_q;

    // -----------------------------------------------------------------------
    // Response data. RAM read data arrives in RESP, one cycle after the
    // ACCESS address, and is shown directly in the pulse cycle; the held
    // registers take over once the pulse is gone.
    // -----------------------------------------------------------------------
    assign rd_word = {mem_ub_rdata, mem_lb_rdata};

    always_comb begin
        core_data = '0;
        if (!write_q && !misalign) begin
            if (byte_q) begin
                core_data = {{(DATA_W-8){1'b0}}, mem_lb_rdata};
            end else begin
                core_data = rd_word;
            end
        end
    end

    assign rsp_valid = in_resp & ~dbg_src_q;
    assign dbg_valid = in_resp &  dbg_src_q;
    assign rsp_fault = rsp_valid & misalign;
    assign rsp_rdata = rsp_valid ? core_data : rsp_rdata_q;
    assign dbg_rdata = dbg_valid ? rd_word   : dbg_rdata_q;

    assign fsm_state = state;

endmodule

// File: tb/tb_xm23_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_xm23_mem_interface
//
// Directed bench for xm23_mem_interface. A byte-addressed RAM model with
// one-cycle read latency sits on the two byte ports. Expected values are
// hand-computed constants; each comparison is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_xm23_mem_interface;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clock = ~Clock;

    // -----------------------------------------------------------------------
    // DUT signals
    // -----------------------------------------------------------------------
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_valid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_lb_addr;
    logic [ADDR_W-1:0] mem_ub_addr;
    logic [7:0]        mem_lb_wdata;
    logic [7:0]        mem_ub_wdata;
    logic              mem_lb_we;
    logic              mem_ub_we;
    logic [7:0]        mem_lb_rdata;
    logic [7:0]        mem_ub_rdata;
    logic [1:0]        fsm_state;

    xm23_mem_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_byte     (req_byte),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .dbg_req      (dbg_req),
        .dbg_addr     (dbg_addr),
        .dbg_valid    (dbg_valid),
        .dbg_rdata    (dbg_rdata),
        .mem_lb_addr  (mem_lb_addr),
        .mem_ub_addr  (mem_ub_addr),
        .mem_lb_wdata (mem_lb_wdata),
        .mem_ub_wdata (mem_ub_wdata),
        .mem_lb_we    (mem_lb_we),
        .mem_ub_we    (mem_ub_we),
        .mem_lb_rdata (mem_lb_rdata),
        .mem_ub_rdata (mem_ub_rdata),
        .fsm_state    (fsm_state)
    );

    // -----------------------------------------------------------------------
    // RAM model: byte array, synchronous read (data one cycle after address)
    // -----------------------------------------------------------------------
    logic [7:0] ram [0:65535];

    always @(posedge Clock) begin
        mem_lb_rdata <= ram[mem_lb_addr];
        mem_ub_rdata <= ram[mem_ub_addr];
        if (mem_lb_we) ram[mem_lb_addr] <= mem_lb_wdata;
        if (mem_ub_we) ram[mem_ub_addr] <= mem_ub_wdata;
    end

    // -----------------------------------------------------------------------
    // Counters and comparison helper
    // -----------------------------------------------------------------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One full core transaction from an IDLE cycle with req_ready=1:
    // accept edge, ACCESS-cycle checks, RESP-cycle checks, return-to-IDLE
    // checks. Inputs are scrambled after accept to show they are not
    // re-sampled.
    task automatic core_txn(
        input string       tag,
        input logic        w,
        input logic        b,
        input logic [15:0] a,
        input logic [15:0] d,
        input logic        e_lb_we,
        input logic        e_ub_we,
        input logic [15:0] e_lb_addr,
        input logic [15:0] e_ub_addr,
        input logic [7:0]  e_lb_wdata,
        input logic [7:0]  e_ub_wdata,
        input logic [15:0] e_rdata,
        input logic        e_fault
    );
        check({tag, "/ready_before"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        req_write = ~w;
        req_byte  = ~b;
        req_addr  = 16'hDEAD;
        req_wdata = 16'hBEEF;
        // ACCESS cycle
        check({tag, "/acc_state"}, fsm_state, S_ACCESS);
        check({tag, "/acc_ready"}, req_ready, 1'b0);
        check({tag, "/acc_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "/lb_we"}, mem_lb_we, e_lb_we);
        check({tag, "/ub_we"}, mem_ub_we, e_ub_we);
        if (e_lb_we || !w) check({tag, "/lb_addr"}, mem_lb_addr, e_lb_addr);
        if (e_ub_we || (!w && !b)) check({tag, "/ub_addr"}, mem_ub_addr, e_ub_addr);
        if (e_lb_we) check({tag, "/lb_wdata"}, mem_lb_wdata, e_lb_wdata);
        if (e_ub_we) check({tag, "/ub_wdata"}, mem_ub_wdata, e_ub_wdata);
        step();
        // RESP cycle
        check({tag, "/rsp_valid"}, rsp_valid, 1'b1);
        check({tag, "/rsp_rdata"}, rsp_rdata, e_rdata);
        check({tag, "/rsp_fault"}, rsp_fault, e_fault);
        check({tag, "/rsp_dbg_valid"}, dbg_valid, 1'b0);
        step();
        // back in IDLE
        check({tag, "/idle_state"}, fsm_state, S_IDLE);
        check({tag, "/idle_ready"}, req_ready, 1'b1);
        check({tag, "/idle_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "/rdata_hold"}, rsp_rdata, e_rdata);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        dbg_req   = 1'b0;
        dbg_addr  = '0;

        // --- reset values --------------------------------------------------
        #1;
        check("rst/state", fsm_state, S_IDLE);
        check("rst/ready", req_ready, 1'b0);
        check("rst/rsp_valid", rsp_valid, 1'b0);
        check("rst/rsp_rdata", rsp_rdata, 16'h0000);
        check("rst/rsp_fault", rsp_fault, 1'b0);
        check("rst/dbg_valid", dbg_valid, 1'b0);
        check("rst/dbg_rdata", dbg_rdata, 16'h0000);
        check("rst/lb_we", mem_lb_we, 1'b0);
        check("rst/ub_we", mem_ub_we, 1'b0);
        check("rst/lb_addr", mem_lb_addr, 16'h0000);
        check("rst/ub_addr", mem_ub_addr, 16'h0000);
        step();
        step();
        check("rst/ready_held", req_ready, 1'b0);
        Reset_n = 1'b1;
        step();
        check("rel/ready", req_ready, 1'b1);
        check("rel/state", fsm_state, S_IDLE);

        // --- basic word / byte traffic -------------------------------------
        core_txn("wr_w_0100", 1'b1, 1'b0, 16'h0100, 16'h1234,
                 1'b1, 1'b1, 16'h0100, 16'h0101, 8'h34, 8'h12, 16'h0000, 1'b0);
        core_txn("rd_w_0100", 1'b0, 1'b0, 16'h0100, 16'h0000,
                 1'b0, 1'b0, 16'h0100, 16'h0101, 8'h00, 8'h00, 16'h1234, 1'b0);
        core_txn("rd_b_0101", 1'b0, 1'b1, 16'h0101, 16'h0000,
                 1'b0, 1'b0, 16'h0101, 16'h0101, 8'h00, 8'h00, 16'h0012, 1'b0);
        core_txn("wr_b_0101", 1'b1, 1'b1, 16'h0101, 16'h77AB,
                 1'b1, 1'b0, 16'h0101, 16'h0101, 8'hAB, 8'h00, 16'h0000, 1'b0);
        core_txn("rd_w_0100b", 1'b0, 1'b0, 16'h0100, 16'h0000,
                 1'b0, 1'b0, 16'h0100, 16'h0101, 8'h00, 8'h00, 16'hAB34, 1'b0);

        // --- misaligned word accesses --------------------------------------
`ifdef XM23_MEMIF_ALIGN_FAULT_EN
        core_txn("wr_w_0103", 1'b1, 1'b0, 16'h0103, 16'h5678,
                 1'b0, 1'b0, 16'h0102, 16'h0103, 8'h00, 8'h00, 16'h0000, 1'b1);
        core_txn("rd_w_0102", 1'b0, 1'b0, 16'h0102, 16'h0000,
                 1'b0, 1'b0, 16'h0102, 16'h0103, 8'h00, 8'h00, 16'h0000, 1'b0);
        core_txn("rd_w_0101", 1'b0, 1'b0, 16'h0101, 16'h0000,
                 1'b0, 1'b0, 16'h0100, 16'h0101, 8'h00, 8'h00, 16'h0000, 1'b1);
`else
        core_txn("wr_w_0103", 1'b1, 1'b0, 16'h0103, 16'h5678,
                 1'b1, 1'b1, 16'h0102, 16'h0103, 8'h78, 8'h56, 16'h0000, 1'b0);
        core_txn("rd_w_0102", 1'b0, 1'b0, 16'h0102, 16'h0000,
                 1'b0, 1'b0, 16'h0102, 16'h0103, 8'h00, 8'h00, 16'h5678, 1'b0);
        core_txn("rd_w_0101", 1'b0, 1'b0, 16'h0101, 16'h0000,
                 1'b0, 1'b0, 16'h0100, 16'h0101, 8'h00, 8'h00, 16'hAB34, 1'b0);
`endif

        // --- top-of-memory boundary, no carry ------------------------------
        core_txn("wr_w_fffe", 1'b1, 1'b0, 16'hFFFE, 16'hCAFE,
                 1'b1, 1'b1, 16'hFFFE, 16'hFFFF, 8'hFE, 8'hCA, 16'h0000, 1'b0);
        core_txn("rd_b_ffff", 1'b0, 1'b1, 16'hFFFF, 16'h0000,
                 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 8'h00, 8'h00, 16'h00CA, 1'b0);
        core_txn("wr_b_ffff", 1'b1, 1'b1, 16'hFFFF, 16'h005A,
                 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 8'h5A, 8'h00, 16'h0000, 1'b0);
        core_txn("rd_w_fffe", 1'b0, 1'b0, 16'hFFFE, 16'h0000,
                 1'b0, 1'b0, 16'hFFFE, 16'hFFFF, 8'h00, 8'h00, 16'h5AFE, 1'b0);

        // --- core and debug requested together: core first ------------------
        dbg_req  = 1'b1;
        dbg_addr = 16'h0100;
        core_txn("arb_core", 1'b0, 1'b0, 16'h0100, 16'h0000,
                 1'b0, 1'b0, 16'h0100, 16'h0101, 8'h00, 8'h00, 16'hAB34, 1'b0);
        step();  // debug accepted at this edge
        check("arb_dbg/acc_state", fsm_state, S_ACCESS);
        check("arb_dbg/acc_ready", req_ready, 1'b0);
        check("arb_dbg/lb_addr", mem_lb_addr, 16'h0100);
        check("arb_dbg/lb_we", mem_lb_we, 1'b0);
        dbg_req  = 1'b0;
        dbg_addr = 16'h4444;
        step();
        check("arb_dbg/dbg_valid", dbg_valid, 1'b1);
        check("arb_dbg/dbg_rdata", dbg_rdata, 16'hAB34);
        check("arb_dbg/rsp_valid", rsp_valid, 1'b0);
        check("arb_dbg/rsp_rdata_hold", rsp_rdata, 16'hAB34);
        step();
        check("arb_dbg/dbg_valid_off", dbg_valid, 1'b0);
        check("arb_dbg/dbg_rdata_hold", dbg_rdata, 16'hAB34);
        check("arb_dbg/ready", req_ready, 1'b1);

        // --- debug read at an odd address is aligned, never faults ----------
        dbg_req  = 1'b1;
        dbg_addr = 16'hFFFF;
        step();
        dbg_req  = 1'b0;
        dbg_addr = 16'h0000;
        check("dbg_ffff/lb_addr", mem_lb_addr, 16'hFFFE);
        check("dbg_ffff/ub_addr", mem_ub_addr, 16'hFFFF);
        step();
        check("dbg_ffff/dbg_valid", dbg_valid, 1'b1);
        check("dbg_ffff/dbg_rdata", dbg_rdata, 16'h5AFE);
        check("dbg_ffff/rsp_fault", rsp_fault, 1'b0);
        check("dbg_ffff/rsp_valid", rsp_valid, 1'b0);
        step();

        // --- reset asserted during a write's ACCESS cycle -------------------
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h0100;
        req_wdata = 16'h9999;
        step();
        req_valid = 1'b0;
        check("rst_mid/we_before", mem_lb_we, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_mid/lb_we_drop", mem_lb_we, 1'b0);
        check("rst_mid/ub_we_drop", mem_ub_we, 1'b0);
        check("rst_mid/state", fsm_state, S_IDLE);
        check("rst_mid/ready", req_ready, 1'b0);
        step();
        check("rst_mid/no_rsp", rsp_valid, 1'b0);
        Reset_n = 1'b1;
        check("rst_mid/ready_low", req_ready, 1'b0);
        step();
        check("rst_mid/ready_back", req_ready, 1'b1);
        core_txn("rst_mid_rd", 1'b0, 1'b0, 16'h0100, 16'h0000,
                 1'b0, 1'b0, 16'h0100, 16'h0101, 8'h00, 8'h00, 16'hAB34, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
